sniffer_sdram_writer: RTL
=========================

Name: sniffer_sdram_writer

Overview:
- Avalon-MM write master that drains the sniffer's captured-word FIFO into a circular SDRAM buffer.
- Each packet is written as one record: START_WORD, the packet's data words in FIFO order, then STOP_WORD.
- Sits directly downstream of the ethernetsniffer top-level FIFO (rdempty/rdreq/data_out) and drives the bus-master port of the custom slave.
- The slave's CSR file supplies enable and reads back wr_ptr, pkt_count and trunc_count.

Parameters:
ADDR_WIDTH, 26, master byte-address width
DATA_WIDTH, 32, bus data width (fixed at 32; other values unsupported)
BASE_ADDR, 26'h0000000, byte address of ring-buffer word 0 (must be 4-byte aligned)
BUF_WORDS, 1024, ring size in 32-bit words (power of 2, at least 4)
MAX_WORDS, 512, maximum data words per record before forced truncation
START_WORD, 32'hF00BF00B, record header word
STOP_WORD, 32'hDEADF00B, record trailer word

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
enable  in  1  start new records when high
fifo_rdempty  in  1  FIFO empty
fifo_q  in  33  FIFO read data; bit 32 = end-of-packet, [31:0] = data word
fifo_rdreq  out  1  FIFO read request, one pulse per word
master_address  out  ADDR_WIDTH  write byte address
master_writedata  out  32  write data
master_write  out  1  write request
master_waitrequest  in  1  slave stall
wr_ptr  out  log2(BUF_WORDS)  ring index of the next word to be written
pkt_count  out  32  completed records (wraps at 2^32)
trunc_count  out  16  records truncated at MAX_WORDS (saturates at 16'hFFFF)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: when reset_n = 0 at a clock edge, all outputs go to 0 and the FSM goes to IDLE. This takes precedence over everything, including mid-transfer; the partial record is abandoned and no stop word is written.
- FIFO timing: normal (non-show-ahead) mode; fifo_q is valid the cycle after fifo_rdreq.
- fifo_rdreq is asserted only when fifo_rdempty = 0, for exactly one cycle per word.
- Avalon rule: while master_write = 1 and master_waitrequest = 1, master_address, master_writedata and master_write hold stable.
- A write completes on a cycle with master_write = 1 and master_waitrequest = 0. wr_ptr increments only on completion.
- Addressing: master_address = BASE_ADDR + 4 * wr_ptr.
- wr_ptr wraps from BUF_WORDS-1 to 0. Old data is overwritten silently; there is no full condition.
- FSM states:
  - IDLE: go to HDR when enable = 1 and fifo_rdempty = 0.
  - HDR: drive START_WORD with master_write = 1. On completion, clear the word counter and go to FETCH.
  - FETCH: wait while fifo_rdempty = 1. Otherwise pulse fifo_rdreq and go to LATCH.
  - LATCH: register fifo_q into the data and eop holding registers; go to DATA.
  - DATA: drive the held word with master_write = 1. On completion, increment the word counter, then:
    - if eop = 1, go to TRL;
    - else if the word counter equals MAX_WORDS, set the trunc flag and go to TRL;
    - otherwise go to FETCH.
  - TRL: drive STOP_WORD. On completion, increment pkt_count; increment trunc_count if the trunc flag is set (saturating) and clear the flag; go to IDLE.
- After truncation, the remaining words of that packet stay in the FIFO and are written as the next record, which gets its own START_WORD.
- enable = 0 is sampled only in IDLE; a record in progress always completes with STOP_WORD.
- A record with an eop on its first word produces exactly 3 SDRAM writes.
- Throughput: at best 3 cycles per data word with no waitrequest (FETCH, LATCH, DATA).
- master_write is 0 in IDLE, FETCH and LATCH.

Test Plan:
1. Basic record: enable = 1; FIFO holds {0,A1}, {0,A2}, {1,A3}; no waitrequest -> writes of F00BF00B, A1, A2, A3, DEADF00B to addresses 0x0, 0x4, 0x8, 0xC, 0x10; wr_ptr = 5; pkt_count = 1; exactly 3 rdreq pulses.
2. Waitrequest stall: as scenario 1, with waitrequest held high for 4 cycles on the A2 write -> address 0x8 and data A2 stable all 4 cycles; no extra rdreq; final memory image identical to scenario 1.
3. Wrap: BUF_WORDS = 4, wr_ptr starting at 2, 1-word packet {1,B1} -> addresses 0x8, 0xC, 0x0; wr_ptr = 1.
4. Truncation: MAX_WORDS = 2; packet of 3 words C1, C2, C3 (eop on C3) -> record 1 is START, C1, C2, STOP; record 2 is START, C3, STOP; pkt_count = 2; trunc_count = 1.
5. Empty FIFO mid-packet and enable drop: after C1, rdempty = 1 for 10 cycles and enable goes low -> FSM waits in FETCH; when C2 (eop) arrives the record completes with STOP; FSM then stays in IDLE with busy = 0.
6. Reset mid-DATA with waitrequest high -> next cycle master_write = 0, fifo_rdreq = 0, wr_ptr = 0, pkt_count = 0, busy = 0.

Source files
------------

// File: rtl/sniffer_sdram_writer.sv
// Avalon-MM write master: drains the sniffer capture FIFO into a circular SDRAM buffer,
// framing each packet as START_WORD, data words, STOP_WORD.
module sniffer_sdram_writer #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned BUF_WORDS = 1024,
    parameter int unsigned MAX_WORDS = 512,
    parameter logic [DATA_WIDTH-1:0] START_WORD = 32'hF00BF00B,
    parameter logic [DATA_WIDTH-1:0] STOP_WORD = 32'hDEADF00B,
    localparam int unsigned PTR_W = $clog2(BUF_WORDS),
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_rdempty,
    input  logic [DATA_WIDTH:0]   fifo_q,
    output logic                  fifo_rdreq,
    output logic [ADDR_WIDTH-1:0] master_address,
    output logic [DATA_WIDTH-1:0] master_writedata,
    output logic                  master_write,
    input  logic                  master_waitrequest,
    output logic [PTR_W-1:0]      wr_ptr,
    output logic [31:0]           pkt_count,
    output logic [15:0]           trunc_count,
    output logic                  busy
);

    typedef enum logic [2:0] {StIdle, StHdr, StFetch, StLatch, StData, StTrl} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  eop_q;
    logic                  trunc_q, trunc_d;
    logic [31:0]           pkt_count_q;
    logic [15:0]           trunc_count_q;
    logic                  done;

    assign done = master_write & ~master_waitrequest;

    // Outputs depend only on state_q and held registers, so they stay stable during a stall.
    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        trunc_d          = trunc_q;
        master_write     = 1'b0;
        master_writedata = '0;
        fifo_rdreq       = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable && !fifo_rdempty) state_d = StHdr;
            end
            StHdr: begin
                master_write     = 1'b1;
                master_writedata = START_WORD;
                if (!master_waitrequest) begin
                    word_cnt_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (!fifo_rdempty) begin
                    fifo_rdreq = 1'b1;
                    state_d    = StLatch;
                end
            end
            StLatch: state_d = StData;
            StData: begin
                master_write     = 1'b1;
                master_writedata = data_q;
                if (!master_waitrequest) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (eop_q) begin
                        state_d = StTrl;
                    end else if (word_cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                        trunc_d = 1'b1;
                        state_d = StTrl;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StTrl: begin
                master_write     = 1'b1;
                master_writedata = STOP_WORD;
                if (!master_waitrequest) begin
                    trunc_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            word_cnt_q    <= '0;
            data_q        <= '0;
            eop_q         <= 1'b0;
            trunc_q       <= 1'b0;
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            trunc_q    <= trunc_d;
            // BUF_WORDS is a power of two, so the pointer wraps naturally.
            if (done) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (state_q == StLatch) begin
                eop_q  <= fifo_q[DATA_WIDTH];
                data_q <= fifo_q[DATA_WIDTH-1:0];
            end
            if (state_q == StTrl && done) begin
                pkt_count_q <= pkt_count_q + 1'b1;
                if (trunc_q && trunc_count_q != 16'hFFFF) trunc_count_q <= trunc_count_q + 1'b1;
            end
        end
    end

    assign master_address = BASE_ADDR + ADDR_WIDTH'({wr_ptr_q, 2'b00});
    assign wr_ptr         = wr_ptr_q;
    assign pkt_count      = pkt_count_q;
    assign trunc_count    = trunc_count_q;
    assign busy           = (state_q != StIdle);

endmodule
